// File: rtl/reg_scan_if.sv
// reg_scan_if: command, bank-read and output-stream signals of the reg_scan sequencer.
// master = the side driving commands, returning bank data and consuming the stream;
// slave  = reg_scan itself.
interface reg_scan_if #(
    parameter int AW    = 7,
    parameter int WIDTH = 16
);
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW-1:0]    count;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;

    modport master (
        output start, base_addr, count, rd_data, out_ready,
        input  rd_en, rd_addr, out_data, out_valid, busy, done, checksum
    );

    modport slave (
        input  start, base_addr, count, rd_data, out_ready,
        output rd_en, rd_addr, out_data, out_valid, busy, done, checksum
    );
endinterface

// File: rtl/reg_scan.sv
// reg_scan: sweeps a wrap-around address range of the register bank and streams the
// words out in address order through a 2-entry skid FIFO.
// Optional feature macro REG_SCAN_CHECKSUM_EN: builds the running output checksum;
// without it checksum is tied to 0.
// A word returning from the bank is presented on the output in the same cycle it
// arrives when the FIFO is empty; if not accepted it is parked in the FIFO, so the
// presented word stays stable under backpressure.
module reg_scan #(
    parameter int DEPTH = 100,
    parameter int WIDTH = 16,
    parameter int AW    = 7
) (
    input logic        clk,
    input logic        reset,
    reg_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    n_words;
    logic [AW-1:0]    issue_cnt;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    n_eff;
    logic             inflight;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             head_vld;
    logic             pop;
    logic             fifo_push;
    logic             fifo_pop;
    logic             credit;
    logic             last_issue;
    logic             done_q;
    logic [2:0]       held;

    // Credit/occupancy bookkeeping: "held" is what remains buffered after this cycle's pop.
    always_comb begin
        n_eff      = (bus.count > AW'(DEPTH)) ? AW'(DEPTH) : bus.count;
        head_vld   = (fifo_cnt != 2'd0);
        pop        = (head_vld || inflight) && bus.out_ready;
        held       = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
        credit     = (held < 3'd2);
        fifo_pop   = pop && head_vld;
        // an arriving word skips the FIFO only when it is consumed straight away
        fifo_push  = inflight && !(pop && !head_vld);
        last_issue = (issue_cnt == n_words - AW'(1));
    end

    assign bus.rd_en     = (state == ISSUE) && credit;
    assign bus.rd_addr   = addr;
    assign bus.out_valid = head_vld || inflight;
    assign bus.out_data  = head_vld ? fifo_mem[rd_ptr] : (inflight ? bus.rd_data : '0);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

    // Sweep control: latch the command, issue reads under credit, wait for the last accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            n_words   <= '0;
            issue_cnt <= '0;
            addr      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (bus.start) begin
                    n_words   <= n_eff;
                    issue_cnt <= '0;
                    addr      <= bus.base_addr;
                    state     <= (n_eff == '0) ? DONE : ISSUE;
                end
                ISSUE: if (bus.rd_en) begin
                    issue_cnt <= issue_cnt + AW'(1);
                    // address stays on the last read so rd_addr holds once issue stops
                    if (last_issue) state <= DRAIN;
                    else addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
                end
                DRAIN: if (held == 3'd0) state <= DONE;
                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-flight flag and FIFO pointers; reset discards anything still returning.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            inflight <= bus.rd_en;
            if (fifo_push) wr_ptr <= ~wr_ptr;
            if (fifo_pop)  rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // FIFO storage needs no reset: fifo_cnt gates every read of it.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= bus.rd_data;
    end

`ifdef REG_SCAN_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;

    // Running sum of accepted words, restarted by each accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          sum_q <= '0;
        else if (state == IDLE && bus.start) sum_q <= '0;
        else if (pop)                        sum_q <= sum_q + bus.out_data;
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_reg_scan.sv
// tb_reg_scan: scoreboard bench for reg_scan. The sweep driver pushes the expected
// read addresses and words (computed from base/count with modulo arithmetic) into
// queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_reg_scan;
    localparam int DEPTH = 100;
    localparam int WIDTH = 16;
    localparam int AW    = 7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_scan_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

    reg_scan #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // bank contents: regs[i] = i + 0x100, one-cycle read latency
    logic [WIDTH-1:0] bank [DEPTH];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= bank[bus.rd_addr];

    logic [WIDTH-1:0] exp_w[$];
    int               exp_a[$];
    logic [WIDTH-1:0] sum_exp;
    int  t0, exp_n, ov_cyc, busy_cyc, issued, emitted;
    bit  tmode, done_seen, rd_seen, ov_seen, mon_en, prev_stall;
    logic [WIDTH-1:0] prev_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares reads, output words, stall stability and end-of-sweep results.
    always @(negedge clk) begin
        if (reset && mon_en) begin
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.busy) busy_cyc++;
            if (bus.rd_en) begin
                issued++;
                if (!rd_seen) begin
                    rd_seen = 1;
                    chk("first_rd_latency", cyc - t0, 1);
                end
                chk("rd_en_while_busy", bus.busy, 1);
                if (exp_a.size() == 0) chk("rd_count", issued, exp_n);
                else                   chk("rd_addr", bus.rd_addr, exp_a.pop_front());
            end
            if (bus.out_valid && !ov_seen) begin
                ov_seen = 1;
                ov_cyc  = cyc;
                chk("first_valid_latency", cyc - t0, 2);
            end
            if (bus.out_valid && bus.out_ready) begin
                emitted++;
                if (exp_w.size() == 0) chk("emit_count", emitted, exp_n);
                else                   chk("out_data", bus.out_data, exp_w.pop_front());
            end
            if (bus.done) begin
                done_seen = 1;
                if (tmode) begin
                    chk("done_latency", cyc - t0, (exp_n == 0) ? 2 : exp_n + 3);
                    chk("busy_cycles", busy_cyc, (exp_n == 0) ? 1 : exp_n + 2);
                end
                chk("words_left", exp_w.size(), 0);
                chk("addrs_left", exp_a.size(), 0);
`ifdef REG_SCAN_CHECKSUM_EN
                chk("checksum", bus.checksum, sum_exp);
`else
                chk("checksum", bus.checksum, 0);
`endif
            end
        end
    end

    // mode 0: ready high; 1: random ready; 2: stall 5 cycles after first word then toggle
    task automatic sweep(input int b, input int c, input int mode, input bit inject);
        int n;
        n = (c > DEPTH) ? DEPTH : c;
        exp_w.delete();
        exp_a.delete();
        sum_exp = '0;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (b + i) % DEPTH;
            exp_a.push_back(a);
            exp_w.push_back(WIDTH'(a + 'h100));
            sum_exp = sum_exp + WIDTH'(a + 'h100);
        end
        exp_n = n; tmode = (mode == 0);
        done_seen = 0; rd_seen = 0; ov_seen = 0; issued = 0; emitted = 0;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = AW'(b);
        bus.count     = AW'(c);
        bus.out_ready = (mode != 2);
        t0 = cyc;
        busy_cyc = 0;
        for (int k = 0; k < 3000 && !done_seen; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (inject && k == 20) begin
                bus.start     = 1'b1;
                bus.base_addr = AW'(50);
                bus.count     = AW'(3);
            end
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!ov_seen || cyc < ov_cyc + 5) bus.out_ready = 1'b0;
                    else                              bus.out_ready = ~bus.out_ready;
                end
            endcase
            if (mode == 2 && ov_seen && cyc == ov_cyc + 4) begin
                chk("stall_issued", issued, 2);
                chk("stall_rd_en", bus.rd_en, 0);
            end
        end
        chk("done_seen", done_seen, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) bank[i] = WIDTH'(i + 'h100);
        bus.start = 1'b0; bus.base_addr = '0; bus.count = '0;
        bus.out_ready = 1'b0; bus.rd_data = '0;
        mon_en = 0; prev_stall = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_checksum", bus.checksum, 0);
        reset = 1'b1;
        mon_en = 1;

        sweep(0, 4, 0, 0);
        sweep(98, 4, 0, 0);
        sweep(0, 0, 0, 0);
        sweep(10, 6, 2, 0);
        sweep(0, 120, 0, 1);

        // abort mid-sweep with one word in flight
        mon_en = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = AW'(40); bus.count = AW'(10); bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_inflight", bus.out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_outputs", {bus.rd_en, bus.out_valid, bus.busy, bus.done}, 0);
        chk("abort_rd_addr", bus.rd_addr, 0);
        chk("abort_out_data", bus.out_data, 0);
        chk("abort_checksum", bus.checksum, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_hold", {bus.rd_en, bus.out_valid, bus.busy, bus.done}, 0);
        reset = 1'b1;
        prev_stall = 0;
        mon_en = 1;
        sweep(5, 2, 0, 0);

        for (int r = 0; r < 15; r++) begin
            int b, c, m;
            b = $urandom_range(0, DEPTH - 1);
            c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
            m = $urandom_range(0, 1);
            sweep(b, c, m, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
